// File: rtl/id_ex_stage_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: field widths, control-bit
// positions inside the WB/M groups and the ALUOp encodings seen by execute.
package id_ex_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned WB_W    = 2;
  localparam int unsigned M_W     = 3;
  localparam int unsigned ALUOP_W = 4;

  // WB group: {RegWrite, MemtoReg}
  localparam int unsigned WB_REGWRITE_BIT = 1;
  localparam int unsigned WB_MEMTOREG_BIT = 0;

  // M group: {Branch, MemRead, MemWrite}
  localparam int unsigned M_BRANCH_BIT   = 2;
  localparam int unsigned M_MEMREAD_BIT  = 1;
  localparam int unsigned M_MEMWRITE_BIT = 0;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_AND = 4'h0,
    ALUOP_OR  = 4'h1,
    ALUOP_ADD = 4'h2,
    ALUOP_SUB = 4'h6,
    ALUOP_SLT = 4'h7,
    ALUOP_NOR = 4'hC
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_reg_pipe_field_reg.sv
// Generic pipeline field register: async reset, hold enable, synchronous clear.
// Clear takes priority over hold so a flush can bubble a stalled stage.
module pipe_field_reg
#(
  parameter int unsigned W = 1
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  import id_ex_pkg::*;

  logic [W-1:0] field_q;
  logic [W-1:0] field_d;

  always_comb begin
    field_d = field_q;
    if (clr) begin
      field_d = '0;
    end else if (en) begin
      field_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field_q <= '0;
    end else begin
      field_q <= field_d;
    end
  end

  assign q = field_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/flush, valid bit and split EX control.
// Optional saturating stall/flush counters when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage_reg
#(
  parameter int unsigned DATA_W  = id_ex_pkg::DATA_W,
  parameter int unsigned REG_W   = id_ex_pkg::REG_W,
  parameter int unsigned WB_W    = id_ex_pkg::WB_W,
  parameter int unsigned M_W     = id_ex_pkg::M_W,
  parameter int unsigned ALUOP_W = id_ex_pkg::ALUOP_W
)
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               ValidIn,
  input  logic [DATA_W-1:0]  PCIn,
  input  logic [DATA_W-1:0]  ReadData1In,
  input  logic [DATA_W-1:0]  ReadData2In,
  input  logic [DATA_W-1:0]  SignExtIn,
  input  logic [REG_W-1:0]   RsIn,
  input  logic [REG_W-1:0]   RtIn,
  input  logic [REG_W-1:0]   RdIn,
  input  logic [WB_W-1:0]    WBCtrlIn,
  input  logic [M_W-1:0]     MCtrlIn,
  input  logic               RegDstIn,
  input  logic               ALUSrcIn,
  input  logic [ALUOP_W-1:0] ALUOpIn,
  output logic [DATA_W-1:0]  PCOut,
  output logic [DATA_W-1:0]  ReadData1Out,
  output logic [DATA_W-1:0]  ReadData2Out,
  output logic [DATA_W-1:0]  SignExtOut,
  output logic [REG_W-1:0]   RsOut,
  output logic [REG_W-1:0]   RtOut,
  output logic [REG_W-1:0]   RdOut,
  output logic [WB_W-1:0]    WBCtrlOut,
  output logic [M_W-1:0]     MCtrlOut,
  output logic               RegDstOut,
  output logic               ALUSrcOut,
  output logic [ALUOP_W-1:0] ALUOpOut,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]        StallCount,
  output logic [31:0]        FlushCount,
`endif
  output logic               ValidOut
);
  import id_ex_pkg::*;

  localparam int unsigned DATA_GRP_W = 4*DATA_W + 3*REG_W;
  localparam int unsigned CTRL_GRP_W = WB_W + M_W + 2 + ALUOP_W;

  logic                  data_en;
  logic                  ctrl_en;
  logic [DATA_GRP_W-1:0] data_d;
  logic [DATA_GRP_W-1:0] data_q;
  logic [CTRL_GRP_W-1:0] ctrl_d;
  logic [CTRL_GRP_W-1:0] ctrl_q;
  logic                  valid_q;

  // Data fields hold on flush; control and valid are cleared by it instead.
  always_comb begin
    data_en = !Stall && !Flush;
    ctrl_en = !Stall;
    data_d  = {PCIn, ReadData1In, ReadData2In, SignExtIn, RsIn, RtIn, RdIn};
    ctrl_d  = '0;
    if (ValidIn) begin
      ctrl_d = {WBCtrlIn, MCtrlIn, RegDstIn, ALUSrcIn, ALUOpIn};
    end
  end

  pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
    .clk (Clk),
    .rst (Rst),
    .en  (data_en),
    .clr (1'b0),
    .d   (data_d),
    .q   (data_q)
  );

  pipe_field_reg #(.W(CTRL_GRP_W)) u_ctrl_reg (
    .clk (Clk),
    .rst (Rst),
    .en  (ctrl_en),
    .clr (Flush),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  pipe_field_reg #(.W(1)) u_valid_reg (
    .clk (Clk),
    .rst (Rst),
    .en  (ctrl_en),
    .clr (Flush),
    .d   (ValidIn),
    .q   (valid_q)
  );

  assign {PCOut, ReadData1Out, ReadData2Out, SignExtOut, RsOut, RtOut, RdOut} = data_q;
  assign {WBCtrlOut, MCtrlOut, RegDstOut, ALUSrcOut, ALUOpOut}               = ctrl_q;
  assign ValidOut = valid_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // A flush that coincides with a stall is counted only as a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (Stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule
